uni_shift_reg: RTL and testbench
================================

UNI_SHIFT_REG -- requirements
Module: uni_shift_reg

Interface
REQ-001 Parameter WIDTH, default 4, register width in bits (minimum 2); all data ports scale with it.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 clear  input  1  reset, synchronous, active-low.
REQ-004 S  input  2  mode select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-005 I  input  WIDTH  parallel load data.
REQ-006 SIL  input  1  serial input for shift left; enters bit 0.
REQ-007 SIR  input  1  serial input for shift right; enters bit WIDTH-1.
REQ-008 Out  output  WIDTH  register contents, driven directly from flops.

Function
REQ-009 The register SHALL update only on the rising edge of clk; Out SHALL NOT change between edges.
REQ-010 S=00 (hold): Out SHALL retain its value.
REQ-011 S=01 (shift right): Out SHALL become {SIR, Out[WIDTH-1:1]}; Out[0] is discarded.
REQ-012 S=10 (shift left): Out SHALL become {Out[WIDTH-2:0], SIL}; Out[WIDTH-1] is discarded.
REQ-013 S=11 (parallel load): Out SHALL become I.
REQ-014 Latency SHALL be exactly one clock: an operation selected before edge N is visible on Out after edge N.
REQ-015 SIL SHALL be ignored in every mode except 10; SIR SHALL be ignored in every mode except 01; I SHALL be ignored in every mode except 11.
REQ-016 Repeated shifts SHALL NOT wrap around; the bit shifted out is lost and the vacated position is filled from the serial input.
REQ-017 Mode changes SHALL take effect on the next edge with no idle cycle, and every edge SHALL perform exactly one operation.
REQ-018 The block SHALL have no handshake, status outputs or internal state beyond the WIDTH data flops.
REQ-019 If S carries X/Z, Out behaviour is unspecified; the bench SHALL NOT drive X on S after reset is released.

Reset
REQ-020 When clear=0 at a rising clk edge, Out SHALL become all zeros, overriding S, I, SIL and SIR.
REQ-021 Reset SHALL be synchronous: asserting clear without a clk edge SHALL NOT change Out.
REQ-022 Reset asserted during any mode SHALL abort that operation on the same edge; the first edge with clear=1 SHALL perform the selected operation on the zeroed register.

Structure
REQ-023 Mode encodings (HOLD=2'b00, SHR=2'b01, SHL=2'b10, LOAD=2'b11) SHALL be defined as named constants in a shared package, uni_shift_reg_pkg, and used by RTL and bench.
REQ-024 The top level SHALL instantiate WIDTH copies of one sub-module, usr_bit_cell, via generate.
REQ-025 usr_bit_cell SHALL hold one flop with a 4:1 next-state mux (self, left neighbour, right neighbour, parallel bit) plus synchronous active-low clear.
REQ-026 Boundary cells SHALL take SIR (bit WIDTH-1) and SIL (bit 0) as neighbour inputs.

Verification
REQ-027 Reset: Out=4'b1010 loaded, then clear=0 for one edge -> Out=4'b0000, regardless of S, I, SIL and SIR.
REQ-028 Load and hold: clear=1, S=11, I=4'b1011 for one edge -> Out=4'b1011; then S=00 for 3 edges -> Out stays 4'b1011.
REQ-029 Shift right: Out=4'b1011, S=01, SIR=0 -> 4'b0101, then SIR=1 -> 4'b1010.
REQ-030 Shift left: Out=4'b1011, S=10, SIL=1 -> 4'b0111, then SIL=0 -> 4'b1110.
REQ-031 Fill and serial-input isolation: from reset, S=01, SIR=1 for 4 edges -> 0000,1000,1100,1110,1111; SIL toggling throughout has no effect.
REQ-032 Mid-operation reset: shifting left with SIL=1 from 4'b0001, clear=0 on the 2nd edge -> Out=4'b0000; clear=1 on the next edge -> Out=4'b0001.

Source files
------------

// File: rtl/uni_shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// the per-bit next-state selection used by every bit cell.
package uni_shift_reg_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        SHR  = 2'b01,
        SHL  = 2'b10,
        LOAD = 2'b11
    } mode_e;

    // Left neighbour is the next-higher bit (feeds a right shift); right
    // neighbour is the next-lower bit (feeds a left shift).
    function automatic logic next_bit(
        input mode_e mode,
        input logic  self_bit,
        input logic  left_bit,
        input logic  right_bit,
        input logic  par_bit
    );
        logic nxt;
        nxt = self_bit;
        case (mode)
            HOLD:    nxt = self_bit;
            SHR:     nxt = left_bit;
            SHL:     nxt = right_bit;
            LOAD:    nxt = par_bit;
            default: nxt = self_bit;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/usr_bit_cell.sv
// One bit of the universal shift register: a single flop behind a 4:1
// next-state mux with a synchronous active-low clear.
module usr_bit_cell
    import uni_shift_reg_pkg::*;
(
    input  logic  clk,
    input  logic  clear,
    input  mode_e mode,
    input  logic  left_in,
    input  logic  right_in,
    input  logic  par_in,
    output logic  q
);

    // NOTE: clear is sampled only on the clock edge (synchronous reset), and
    // the flop uses a non-blocking assignment so all cells read their
    // neighbours' pre-edge values and shift as one.
    always_ff @(posedge clk) begin
        if (!clear) begin
            q <= 1'b0;
        end else begin
            q <= next_bit(mode, q, left_in, right_in, par_in);
        end
    end

endmodule

// File: rtl/uni_shift_reg.sv
// Universal shift register: hold, shift right, shift left or parallel load
// each clock, built as a chain of identical bit cells.
module uni_shift_reg
    import uni_shift_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [1:0]       S,
    input  logic [WIDTH-1:0] I,
    input  logic             SIL,
    input  logic             SIR,
    output logic [WIDTH-1:0] Out
);

    mode_e mode;
    assign mode = mode_e'(S);

    if (WIDTH < 2) begin : g_width_check
        $error("uni_shift_reg: WIDTH must be at least 2");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic left_bit;
        logic right_bit;

        // The MSB cell shifts in SIR on a right shift; the LSB cell shifts in SIL on a left shift.
        if (i == WIDTH - 1) begin : g_msb
            assign left_bit = SIR;
        end else begin : g_inner_left
            assign left_bit = Out[i+1];
        end

        if (i == 0) begin : g_lsb
            assign right_bit = SIL;
        end else begin : g_inner_right
            assign right_bit = Out[i-1];
        end

        usr_bit_cell u_cell (
            .clk      (clk),
            .clear    (clear),
            .mode     (mode),
            .left_in  (left_bit),
            .right_in (right_bit),
            .par_in   (I[i]),
            .q        (Out[i])
        );
    end

endmodule

// File: tb/tb_uni_shift_reg.sv
// Directed self-checking bench for uni_shift_reg at WIDTH=4; inputs change
// 1ns after each rising edge and Out is checked there as well.
module tb_uni_shift_reg;
    import uni_shift_reg_pkg::*;

    localparam int W = 4;

    logic         clk;
    logic         clear;
    logic [1:0]   S;
    logic [W-1:0] I;
    logic         SIL;
    logic         SIR;
    logic [W-1:0] Out;

    int checks = 0;
    int errors = 0;

    uni_shift_reg #(.WIDTH(W)) dut (
        .clk   (clk),
        .clear (clear),
        .S     (S),
        .I     (I),
        .SIL   (SIL),
        .SIR   (SIR),
        .Out   (Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] expected);
        checks++;
        assert (Out === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, Out, expected);
        end
    endtask

    initial begin
        clear = 1'b0;
        S     = HOLD;
        I     = '0;
        SIL   = 1'b0;
        SIR   = 1'b0;
        tick();
        check("reset_initial", 4'b0000);

        // Load 1010, then reset with every other input trying to interfere.
        clear = 1'b1; S = LOAD; I = 4'b1010;
        tick();
        check("load_1010", 4'b1010);
        clear = 1'b0; S = LOAD; I = 4'b1111; SIL = 1'b1; SIR = 1'b1;
        #3;
        check("reset_no_edge", 4'b1010);
        tick();
        check("reset_overrides", 4'b0000);

        // Load and hold; I and serial inputs must be ignored while holding.
        clear = 1'b1; S = LOAD; I = 4'b1011; SIL = 1'b0; SIR = 1'b0;
        tick();
        check("load_1011", 4'b1011);
        S = HOLD; I = 4'b0000; SIL = 1'b1; SIR = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold", 4'b1011);
        end

        // Out only changes on an edge.
        S = LOAD; I = 4'b0101;
        #3;
        check("no_change_between_edges", 4'b1011);

        // Shift right from 1011.
        S = SHR; SIR = 1'b0; SIL = 1'b1; I = 4'b1111;
        tick();
        check("shr_sir0", 4'b0101);
        SIR = 1'b1; SIL = 1'b0;
        tick();
        check("shr_sir1", 4'b1010);

        // Shift left from 1011; mode changes take effect immediately.
        S = LOAD; I = 4'b1011;
        tick();
        check("reload_1011", 4'b1011);
        S = SHL; SIL = 1'b1; SIR = 1'b0; I = 4'b0000;
        tick();
        check("shl_sil1", 4'b0111);
        SIL = 1'b0; SIR = 1'b1;
        tick();
        check("shl_sil0", 4'b1110);

        // Fill from reset via SIR with SIL toggling; no wrap-around.
        clear = 1'b0;
        tick();
        check("fill_reset", 4'b0000);
        clear = 1'b1; S = SHR; SIR = 1'b1;
        SIL = 1'b1; tick(); check("fill_1", 4'b1000);
        SIL = 1'b0; tick(); check("fill_2", 4'b1100);
        SIL = 1'b1; tick(); check("fill_3", 4'b1110);
        SIL = 1'b0; tick(); check("fill_4", 4'b1111);
        SIL = 1'b1; tick(); check("fill_saturate", 4'b1111);

        // Drain left with SIL=0; the MSB must not wrap into bit 0.
        S = SHL; SIL = 1'b0; SIR = 1'b1;
        tick(); check("drain_1", 4'b1110);
        tick(); check("drain_2", 4'b1100);
        tick(); check("drain_3", 4'b1000);
        tick(); check("drain_4", 4'b0000);

        // Reset in the middle of a left shift, then resume on zeroed register.
        S = LOAD; I = 4'b0001;
        tick();
        check("mid_load_0001", 4'b0001);
        S = SHL; SIL = 1'b1; SIR = 1'b0;
        tick();
        check("mid_shl_1", 4'b0011);
        clear = 1'b0;
        tick();
        check("mid_reset", 4'b0000);
        clear = 1'b1;
        tick();
        check("mid_resume", 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
